ctrl_sequencer: RTL and testbench

Parametrised multi-cycle control sequencer. It is the next generation of the single-cycle opcode decoder. It accepts one instruction opcode at a time through a valid/ready handshake and classifies it as R-type, I-type, jump, branch or NOP. It then steps through DECODE/EXEC/WB states, driving the datapath enables, PC load, pipeline flush and a retire pulse. It sits between instruction fetch and the ALU/register-file/PC logic.

---
 rtl/ctrl_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - multi-cycle opcode sequencer (IDLE/DECODE/EXEC/WB), optional CTRL_SEQ_PERF_CNT_EN retire counter
module ctrl_sequencer #(
    parameter int OPCODE_W  = 4,
    parameter int R_LAST    = 8,
    parameter int JMP_OP    = 5,
    parameter int IMM_FIRST = 9,
    parameter int IMM_LAST  = 11,
    parameter int BR_FIRST  = 12,
    parameter int BR_LAST   = 15,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                stall,
    input  logic                branch_cond,
    output logic                branch_en,
    output logic                jump_en,
    output logic                immediate_en,
    output logic                write_en,
    output logic                pc_load,
    output logic                flush,
    output logic                done,
    output logic [CNT_W-1:0]    retired_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        C_NOP    = 3'd0,
        C_RTYPE  = 3'd1,
        C_ITYPE  = 3'd2,
        C_JUMP   = 3'd3,
        C_BRANCH = 3'd4
    } class_t;

    localparam logic [31:0] JMP_U       = 32'(JMP_OP);
    localparam logic [31:0] IMM_FIRST_U = 32'(IMM_FIRST);
    localparam logic [31:0] IMM_LAST_U  = 32'(IMM_LAST);
    localparam logic [31:0] BR_FIRST_U  = 32'(BR_FIRST);
    localparam logic [31:0] BR_LAST_U   = 32'(BR_LAST);
    localparam logic [31:0] R_LAST_U    = 32'(R_LAST);

    state_t              state_q;
    state_t              state_d;
    logic [OPCODE_W-1:0] op_q;
    logic [31:0]         op_ext;
    class_t              cls;
    logic                accept;

    logic ready_d;
    logic branch_d;
    logic jump_d;
    logic imm_d;
    logic write_d;
    logic pc_load_d;
    logic flush_d;
    logic done_d;

    assign accept = instr_valid && instr_ready;
    assign op_ext = 32'(op_q);

    // Class always comes from the latched opcode; ranges resolve in priority order.
    always_comb begin
        cls = C_NOP;
        if (op_ext == JMP_U) begin
            cls = C_JUMP;
        end else if (op_ext >= IMM_FIRST_U && op_ext <= IMM_LAST_U) begin
            cls = C_ITYPE;
        end else if (op_ext >= BR_FIRST_U && op_ext <= BR_LAST_U) begin
            cls = C_BRANCH;
        end else if (op_ext <= R_LAST_U) begin
            cls = C_RTYPE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (!stall) begin
                    if (cls == C_RTYPE || cls == C_ITYPE) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are computed against the next state so the registered copy lines up with it.
    always_comb begin
        ready_d   = (state_d == S_IDLE);
        branch_d  = (state_d == S_EXEC) && (cls == C_BRANCH);
        jump_d    = (state_d == S_EXEC) && (cls == C_JUMP);
        imm_d     = (state_d == S_EXEC || state_d == S_WB) && (cls == C_ITYPE);
        write_d   = 1'b0;
        pc_load_d = 1'b0;
        flush_d   = 1'b0;
        done_d    = 1'b0;
        if (state_q == S_EXEC && !stall) begin
            done_d = 1'b1;
            case (cls)
                C_RTYPE, C_ITYPE: write_d = 1'b1;
                C_JUMP: begin
                    pc_load_d = 1'b1;
                    flush_d   = 1'b1;
                end
                C_BRANCH: begin
                    pc_load_d = branch_cond;
                    flush_d   = branch_cond;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_ready  <= 1'b1;
            branch_en    <= 1'b0;
            jump_en      <= 1'b0;
            immediate_en <= 1'b0;
            write_en     <= 1'b0;
            pc_load      <= 1'b0;
            flush        <= 1'b0;
            done         <= 1'b0;
        end else begin
            instr_ready  <= ready_d;
            branch_en    <= branch_d;
            jump_en      <= jump_d;
            immediate_en <= imm_d;
            write_en     <= write_d;
            pc_load      <= pc_load_d;
            flush        <= flush_d;
            done         <= done_d;
        end
    end

`ifdef CTRL_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (done_d) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign retired_cnt = cnt_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - randomized self-checking bench for ctrl_sequencer
module tb_ctrl_sequencer;
    localparam int OPCODE_W = 8;
    localparam int CNT_W    = 4;

    localparam int CL_R = 0;
    localparam int CL_I = 1;
    localparam int CL_J = 2;
    localparam int CL_B = 3;
    localparam int CL_N = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                instr_valid;
    logic                instr_ready;
    logic [OPCODE_W-1:0] opcode;
    logic                stall;
    logic                branch_cond;
    logic                branch_en;
    logic                jump_en;
    logic                immediate_en;
    logic                write_en;
    logic                pc_load;
    logic                flush;
    logic                done;
    logic [CNT_W-1:0]    retired_cnt;

    int checks    = 0;
    int failures  = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    ctrl_sequencer #(
        .OPCODE_W(OPCODE_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .stall       (stall),
        .branch_cond (branch_cond),
        .branch_en   (branch_en),
        .jump_en     (jump_en),
        .immediate_en(immediate_en),
        .write_en    (write_en),
        .pc_load     (pc_load),
        .flush       (flush),
        .done        (done),
        .retired_cnt (retired_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input int op);
        if (op == 5) return CL_J;
        if (op >= 9 && op <= 11) return CL_I;
        if (op >= 12 && op <= 15) return CL_B;
        if (op <= 8) return CL_R;
        return CL_N;
    endfunction

    // Packed as {ready, branch_en, jump_en, immediate_en, write_en, pc_load, flush, done}
    task automatic expect_cycle(input string tag, input logic [7:0] ev);
        logic [7:0] obs;
        obs = {instr_ready, branch_en, jump_en, immediate_en, write_en, pc_load, flush, done};
        check_eq(tag, 32'(obs), 32'(ev));
        if (ev[0]) model_cnt++;
`ifdef CTRL_SEQ_PERF_CNT_EN
        check_eq({tag, "_cnt"}, 32'(retired_cnt), 32'(model_cnt % (1 << CNT_W)));
`else
        check_eq({tag, "_cnt"}, 32'(retired_cnt), 32'd0);
`endif
    endtask

    // Called at a negedge in a cycle where instr_ready is expected high; returns likewise.
    task automatic run_instr(input int op, input int nst, input logic bc);
        int    c;
        string t;
        logic  taken;
        c = classify(op);
        t = $sformatf("op%0d_st%0d", op, nst);
        instr_valid = 1'b1;
        opcode      = OPCODE_W'(op);
        stall       = 1'($urandom);
        branch_cond = 1'($urandom);
        @(negedge clk);
        expect_cycle({t, "_dec"}, 8'h00);
        instr_valid = 1'($urandom);
        opcode      = OPCODE_W'($urandom);
        stall       = 1'($urandom);
        @(negedge clk);
        for (int k = 0; k <= nst; k++) begin
            expect_cycle($sformatf("%s_exec%0d", t, k),
                         {1'b0, c == CL_B, c == CL_J, c == CL_I, 4'b0000});
            stall       = (k < nst);
            branch_cond = (k < nst) ? 1'($urandom) : bc;
            instr_valid = 1'($urandom);
            opcode      = OPCODE_W'($urandom);
            @(negedge clk);
        end
        if (c == CL_R || c == CL_I) begin
            expect_cycle({t, "_wb"}, {1'b0, 1'b0, 1'b0, c == CL_I, 1'b1, 1'b0, 1'b0, 1'b1});
            stall       = 1'($urandom);
            instr_valid = 1'b0;
            @(negedge clk);
            expect_cycle({t, "_idle"}, 8'h80);
        end else begin
            taken = (c == CL_J) || (c == CL_B && bc);
            expect_cycle({t, "_ret"}, {1'b1, 4'b0000, taken, taken, 1'b1});
        end
        instr_valid = 1'b0;
        stall       = 1'b0;
    endtask

    initial begin
        int op;
        rst         = 1'b1;
        instr_valid = 1'b0;
        opcode      = '0;
        stall       = 1'b0;
        branch_cond = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_cycle("reset", 8'h80);
        rst = 1'b0;
        @(negedge clk);
        expect_cycle("post_reset", 8'h80);

        run_instr(3, 0, 1'b0);
        run_instr(10, 3, 1'b0);
        run_instr(13, 0, 1'b1);
        run_instr(13, 1, 1'b0);
        run_instr(5, 2, 1'b0);
        run_instr(200, 0, 1'b1);
        run_instr(16, 1, 1'b0);
        run_instr(8, 0, 1'b0);
        run_instr(11, 0, 1'b0);

        // Reset while stalled in EXEC
        instr_valid = 1'b1;
        opcode      = 8'd3;
        stall       = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        expect_cycle("rst_pre_exec", 8'h00);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_cnt = 0;
        expect_cycle("rst_mid_exec", 8'h80);
        rst   = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        expect_cycle("rst_release", 8'h80);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) op = $urandom_range(16, 255);
            else op = $urandom_range(0, 15);
            run_instr(op, $urandom_range(0, 3), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                expect_cycle("gap", 8'h80);
            end
        end

        // 17 back-to-back retires wrap a 4-bit counter to 1
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            run_instr($urandom_range(0, 255), 0, 1'($urandom));
        end
`ifdef CTRL_SEQ_PERF_CNT_EN
        check_eq("wrap_cnt", 32'(retired_cnt), 32'd1);
`else
        check_eq("wrap_cnt", 32'(retired_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
